// File: rtl/twiddle_mult_arbiter.sv
// Round-robin arbiter that shares one two-stage 8+8-bit complex multiplier among
// N_REQ requesters; results leave in grant order, tagged with the requester index.
module twiddle_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_prod,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_valid must not depend on req_ready; the whole pipe moves only when advance is high.

  localparam logic [ID_W:0]   N_REQ_W = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  logic              s1_valid_q, s2_valid_q;
  logic [15:0]       s1_a_q, s1_b_q, s2_prod_q;
  logic [ID_W-1:0]   s1_id_q, s2_id_q;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              advance, grant, found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W:0]     cand;
  logic [15:0]       a_arr [N_REQ];
  logic [15:0]       b_arr [N_REQ];

  assign advance = !s2_valid_q || out_ready;
  assign grant   = advance && found;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[16*i +: 16];
      b_arr[i] = req_b[16*i +: 16];
    end
  end

  // Search ptr, ptr+1, ... modulo N_REQ; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && grant) req_ready[win_id] = 1'b1;
  end

  logic signed [7:0]  ar, ai, br, bi;
  logic signed [15:0] rr, ii, ri, ir, re16, im16;
  logic        [15:0] prod;

  assign ar = s1_a_q[15:8];
  assign ai = s1_a_q[7:0];
  assign br = s1_b_q[15:8];
  assign bi = s1_b_q[7:0];

  assign rr = 16'(ar) * 16'(br);
  assign ii = 16'(ai) * 16'(bi);
  assign ri = 16'(ar) * 16'(bi);
  assign ir = 16'(ai) * 16'(br);

  // Sums kept to 16 bits: bit 16 is dropped so overflow wraps without saturation.
  assign re16 = rr - ii;
  assign im16 = ri + ir;
  assign prod = {8'(re16 >>> 8), 8'(im16 >>> 8)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
    end else if (advance) begin
      s1_valid_q <= grant;
      if (grant) begin
        s1_a_q  <= a_arr[win_id];
        s1_b_q  <= b_arr[win_id];
        s1_id_q <= win_id;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_q <= prod;
        s2_id_q   <= s1_id_q;
      end
      ptr_q <= ptr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_prod  = s2_prod_q;
  assign out_id    = s2_id_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule
